// File: rtl/ps2_pkg.sv
// ============================================================================
// Module      : ps2_pkg
// Description : Shared constants and frame-state encoding for the PS/2
//               keycode receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
  localparam int         PS2_DATA_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

endpackage

`default_nettype wire

// File: rtl/ps2_frame_rx.sv
// ============================================================================
// Module      : ps2_frame_rx
// Description : PS/2 frame receiver: input synchronizers, ps2_clk glitch
//               filter, start/data/parity/stop FSM and inter-edge watchdog.
//               Parity checking is enabled by defining PS2_PARITY_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_done,
  output logic       rx_err,
  output logic       rx_timeout,
  output logic       busy
);

  localparam int FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BCNT_W = $clog2(PS2_DATA_BITS);

  localparam logic [FCNT_W-1:0] FILT_LAST = FCNT_W'(FILTER_LEN - 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BCNT_W-1:0] BIT_LAST  = BCNT_W'(PS2_DATA_BITS - 1);

  logic              clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d;
  logic              dat_meta_q, dat_meta_d, dat_sync_q, dat_sync_d;
  logic              filt_q, filt_d, filt_prev_q, filt_prev_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [7:0]        shift_q, shift_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  ps2_state_e        state_q, state_d;

  logic sample_ev;
  logic sample_bit;
  logic timeout;
  logic par_ok;

  always_comb begin
    clk_meta_d  = ps2_clk;
    clk_sync_d  = clk_meta_q;
    dat_meta_d  = ps2_data;
    dat_sync_d  = dat_meta_q;
    filt_prev_d = filt_q;
  end

  // The filtered clock follows only once the synchronized level has differed for FILTER_LEN cycles.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_sync_q != filt_q) begin
      if (fcnt_q == FILT_LAST) begin
        filt_d = clk_sync_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  assign sample_ev  = filt_prev_q & ~filt_q;
  assign sample_bit = dat_sync_q;
  assign timeout    = (state_q != IDLE) && !sample_ev && (wd_q == WD_LAST);

  always_comb begin
    wd_d = wd_q + 1'b1;
    if (sample_ev || state_q == IDLE || timeout) begin
      wd_d = '0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      dat_meta_q  <= 1'b1;
      dat_sync_q  <= 1'b1;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      fcnt_q      <= '0;
      wd_q        <= '0;
      shift_q     <= '0;
      bcnt_q      <= '0;
    end else begin
      clk_meta_q  <= clk_meta_d;
      clk_sync_q  <= clk_sync_d;
      dat_meta_q  <= dat_meta_d;
      dat_sync_q  <= dat_sync_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_prev_d;
      fcnt_q      <= fcnt_d;
      wd_q        <= wd_d;
      shift_q     <= shift_d;
      bcnt_q      <= bcnt_d;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = IDLE;
    end else if (sample_ev) begin
      case (state_q)
        IDLE:    if (!sample_bit) state_d = DATA;
        DATA:    if (bcnt_q == BIT_LAST) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    shift_d = shift_q;
    bcnt_d  = bcnt_q;
    if (sample_ev) begin
      if (state_q == IDLE) begin
        bcnt_d = '0;
      end else if (state_q == DATA) begin
        shift_d = {sample_bit, shift_q[7:1]};
        bcnt_d  = bcnt_q + 1'b1;
      end
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (sample_ev && state_q == PARITY) begin
      par_d = sample_bit;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign par_ok = ^{shift_q, par_q};
`else
  // The parity slot is still clocked through PARITY but its value is not kept.
  assign par_ok = 1'b1;
`endif

  always_comb begin
    rx_byte    = shift_q;
    rx_done    = 1'b0;
    rx_err     = 1'b0;
    rx_timeout = timeout;
    busy       = (state_q != IDLE);
    if (sample_ev && state_q == STOP) begin
      rx_done = sample_bit & par_ok;
      rx_err  = ~(sample_bit & par_ok);
    end
    if (timeout) begin
      rx_err = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ps2_keycode_rx.sv
// ============================================================================
// Module      : ps2_keycode_rx
// Description : PS/2 keyboard scancode receiver with E0/F0 prefix stripping.
//               Define PS2_PARITY_CHECK_EN to reject frames with bad parity.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_keycode_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  output logic       frame_err,
  output logic       busy
);

  logic [7:0] rx_byte;
  logic       rx_done, rx_err, rx_timeout;

  logic [7:0] key_code_q, key_code_d;
  logic       key_ext_q, key_ext_d, key_break_q, key_break_d;
  logic       key_valid_q, key_valid_d, frame_err_q, frame_err_d;
  logic       ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .FILTER_LEN    (FILTER_LEN)
  ) u_frame_rx (
    .clk       (clk),
    .clr       (clr),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .rx_done   (rx_done),
    .rx_err    (rx_err),
    .rx_timeout(rx_timeout),
    .busy      (busy)
  );

  always_comb begin
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_break_d = key_break_q;
    key_valid_d = 1'b0;
    frame_err_d = rx_err;
    ext_pend_d  = ext_pend_q;
    brk_pend_d  = brk_pend_q;
    if (rx_done) begin
      if (rx_byte == PS2_PREFIX_EXT) begin
        ext_pend_d = 1'b1;
      end else if (rx_byte == PS2_PREFIX_BRK) begin
        brk_pend_d = 1'b1;
      end else begin
        key_code_d  = rx_byte;
        key_ext_d   = ext_pend_q;
        key_break_d = brk_pend_q;
        key_valid_d = 1'b1;
        ext_pend_d  = 1'b0;
        brk_pend_d  = 1'b0;
      end
    end
    // A stalled frame breaks any prefix sequence; a rejected frame does not.
    if (rx_timeout) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      key_code_q  <= '0;
      key_ext_q   <= 1'b0;
      key_break_q <= 1'b0;
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
    end else begin
      key_code_q  <= key_code_d;
      key_ext_q   <= key_ext_d;
      key_break_q <= key_break_d;
      key_valid_q <= key_valid_d;
      frame_err_q <= frame_err_d;
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
    end
  end

  assign key_code  = key_code_q;
  assign key_ext   = key_ext_q;
  assign key_break = key_break_q;
  assign key_valid = key_valid_q;
  assign frame_err = frame_err_q;

endmodule

`default_nettype wire

// File: doc/ps2_keycode_rx.md
PS2_KEYCODE_RX -- requirements
Module: ps2_keycode_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16000, giving the inter-edge watchdog length in clk cycles (1 ms at 16 MHz).
REQ-002 SHALL have parameter FILTER_LEN, default 4, giving the clk cycles a synchronized ps2_clk level must hold before the filtered clock accepts it.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock.
REQ-004 SHALL have port clr, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port ps2_clk, input, 1 bit: raw keyboard clock, asynchronous to clk.
REQ-006 SHALL have port ps2_data, input, 1 bit: raw keyboard data, asynchronous to clk.
REQ-007 SHALL have port key_code, output, 8 bits: the last scancode with prefixes stripped.
REQ-008 SHALL have port key_ext, output, 1 bit: key_code was preceded by E0.
REQ-009 SHALL have port key_break, output, 1 bit: key_code was preceded by F0 (key up).
REQ-010 SHALL have port key_valid, output, 1 bit: one-cycle strobe marking new key_code, key_ext and key_break.
REQ-011 SHALL have port frame_err, output, 1 bit: one-cycle strobe on a framing, parity or timeout error.
REQ-012 SHALL have port busy, output, 1 bit: high while a frame is in progress.

Function
REQ-013 SHALL pass ps2_clk and ps2_data each through a 2-flop synchronizer before any use.
REQ-014 SHALL change the filtered clock only after the synchronized ps2_clk has held the new level for FILTER_LEN consecutive clk cycles.
REQ-015 SHALL generate a sample event on each 1->0 transition of the filtered clock, sampling the synchronized ps2_data.
REQ-016 SHALL implement a frame FSM with states IDLE, DATA, PARITY and STOP.
REQ-017 SHALL, in IDLE, enter DATA with bit count 0 on a sample of 0 (start bit), and stay in IDLE on a sample of 1.
REQ-018 SHALL, in DATA, shift samples in LSB first and go to PARITY after the 8th bit.
REQ-019 SHALL, in PARITY, store the sample and go to STOP.
REQ-020 SHALL, in STOP, always return to IDLE; the frame is accepted only if stop=1 and parity is valid per REQ-033.
REQ-021 SHALL pulse frame_err for 1 cycle on a rejected frame, discard its byte and leave the prefix flags unchanged.
REQ-022 SHALL clear the watchdog on every sample event; when not in IDLE and the watchdog reaches TIMEOUT_CYCLES-1, it SHALL go to IDLE, pulse frame_err and clear both prefix flags.
REQ-023 SHALL, on an accepted byte E0, set ext_pending and produce no key_valid.
REQ-024 SHALL, on an accepted byte F0, set brk_pending and produce no key_valid.
REQ-025 SHALL, on any other accepted byte, load key_code with the byte, key_ext with ext_pending and key_break with brk_pending, pulse key_valid, and clear both pending flags.
REQ-026 SHALL assert key_valid or frame_err exactly 1 clk after the cycle in which the stop-bit sample event is detected.
REQ-027 SHALL hold key_code, key_ext and key_break stable between key_valid pulses.
REQ-028 SHALL never assert key_valid and frame_err in the same cycle.
REQ-029 SHALL drive busy high exactly when the FSM is not in IDLE.
REQ-030 SHALL treat AA, FA and all other non-prefix bytes as ordinary codes.

Reset
REQ-031 SHALL, while clr is high, put the FSM in IDLE, force the filtered clock and synchronizers to 1, clear the counters and pending flags, and hold every output at 0.
REQ-032 SHALL discard any frame in progress when clr is asserted mid-frame, with no strobe issued.

Configuration
REQ-033 SHALL, with PS2_PARITY_CHECK_EN defined, reject a frame unless data bits plus parity bit hold an odd number of ones; without PS2_PARITY_CHECK_EN, the parity bit SHALL be sampled and ignored.

Structure
REQ-034 SHALL take the constants PS2_PREFIX_EXT=8'hE0, PS2_PREFIX_BRK=8'hF0, PS2_DATA_BITS=8 and the FSM state enum from shared package ps2_pkg.
REQ-035 SHALL contain one sub-module, ps2_frame_rx (synchronizer, filter, FSM, watchdog), with prefix tracking kept in ps2_keycode_rx.

Verification
REQ-036 SHALL be verified by this scenario: frame 1C (bits 0,0,1,1,1,0,0,0), parity 0, stop 1 -> key_valid=1 for 1 cycle, key_code=1C, key_ext=0, key_break=0.
REQ-037 SHALL be verified by this scenario: frames E0, F0, 75 -> a single key_valid, key_code=75, key_ext=1, key_break=1; a following frame 1C -> key_ext=0, key_break=0.
REQ-038 SHALL be verified by this scenario: frame 1C with parity 1 under PS2_PARITY_CHECK_EN -> frame_err 1 cycle, no key_valid, key_code unchanged; without the macro -> key_valid with key_code=1C.
REQ-039 SHALL be verified by this scenario: F0, then 5 bits of a frame, then silence for 16000 cycles -> frame_err, busy=0; a following frame 12 -> key_break=0.
REQ-040 SHALL be verified by this scenario: a 2-cycle low glitch on ps2_clk in IDLE -> no state change, busy=0.
REQ-041 SHALL be verified by this scenario: clr pulsed after bit 4 of a frame, then a good frame 29 -> no strobe from the aborted frame, then key_valid with key_code=29.
